// File: rtl/nw_credit_tx_if.sv
// Link-side bundle for nw_credit_tx: upstream pop handshake, outgoing flit link and credit return.
// Latency: none (wires only).
// Backpressure: in_pop from the transmitter is the only throttle toward the upstream register.
interface nw_credit_tx_if #(
   parameter int FLIT_W = 64
);
   logic              in_valid;
   logic [FLIT_W-1:0] in_data;
   logic              in_head;
   logic              in_tail;
   logic              in_pop;
   logic              link_valid;
   logic [FLIT_W-1:0] link_data;
   logic              link_head;
   logic              link_tail;
   logic              credit_in;

   // Driver side: upstream register plus downstream credit source
   modport master (
      output in_valid, in_data, in_head, in_tail, credit_in,
      input  in_pop, link_valid, link_data, link_head, link_tail
   );

   // Transmitter side
   modport slave (
      input  in_valid, in_data, in_head, in_tail, credit_in,
      output in_pop, link_valid, link_data, link_head, link_tail
   );
endinterface

// File: rtl/nw_credit_tx.sv
// Credit-based link transmitter with head/tail framing check; optional output register via NW_CREDIT_TX_OUTREG_EN.
// Latency: 0 cycles pass-through, 1 cycle when NW_CREDIT_TX_OUTREG_EN is defined.
// Backpressure: pops upstream only while the registered credit count is non-zero; credit_in never reaches in_pop combinationally.
module nw_credit_tx #(
   parameter int FLIT_W  = 64,
   parameter int CREDITS = 4,
   parameter int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   nw_credit_tx_if.slave    bus,
   output logic [CNT_W-1:0] credits_avail,
   output logic             idle,
   output logic             err_credit,
   output logic             err_frame
);

   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_PACKET = 1'b1
   } state_t;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             credit_ovf;
   logic             err_credit_q;
   logic             err_frame_q;
   state_t           state_q;
   logic             send;

   // A flit leaves whenever upstream has one and the downstream buffer has a slot; held off during reset
   assign send       = rst_n && bus.in_valid && (cnt_q != '0);
   assign bus.in_pop = send;

   // Next credit count: sends consume, returns replenish, a return with nothing outstanding saturates and flags
   always_comb begin
      cnt_d      = cnt_q;
      credit_ovf = 1'b0;
      if (send && !bus.credit_in) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else if (!send && bus.credit_in) begin
         if (cnt_q == CRED_MAX) begin
            credit_ovf = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Credit counter and sticky overflow flag; reset refills all credits even if some are outstanding
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q        <= CRED_MAX;
         err_credit_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (credit_ovf) begin
            err_credit_q <= 1'b1;
         end
      end
   end

   // Framing tracker: advances only on a sent flit; bad framing is flagged but the flit still goes out
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         err_frame_q <= 1'b0;
      end else if (send) begin
         case (state_q)
            S_IDLE: begin
               // A body/tail with no open packet is treated as if it had opened one
               if (!bus.in_head) begin
                  err_frame_q <= 1'b1;
               end
               state_q <= bus.in_tail ? S_IDLE : S_PACKET;
            end
            S_PACKET: begin
               // A head inside a packet restarts framing as a fresh packet
               if (bus.in_head) begin
                  err_frame_q <= 1'b1;
               end
               state_q <= bus.in_tail ? S_IDLE : S_PACKET;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign credits_avail = cnt_q;
   assign idle          = (state_q == S_IDLE) && (cnt_q == CRED_MAX);
   assign err_credit    = err_credit_q;
   assign err_frame     = err_frame_q;

`ifdef NW_CREDIT_TX_OUTREG_EN
   logic              link_valid_q;
   logic [FLIT_W-1:0] link_data_q;
   logic              link_head_q;
   logic              link_tail_q;

   // Registered link stage: the popped flit appears one cycle later, zeroed on cycles with no send
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         link_valid_q <= 1'b0;
         link_data_q  <= '0;
         link_head_q  <= 1'b0;
         link_tail_q  <= 1'b0;
      end else begin
         link_valid_q <= send;
         link_data_q  <= send ? bus.in_data : '0;
         link_head_q  <= send && bus.in_head;
         link_tail_q  <= send && bus.in_tail;
      end
   end

   assign bus.link_valid = link_valid_q;
   assign bus.link_data  = link_data_q;
   assign bus.link_head  = link_head_q;
   assign bus.link_tail  = link_tail_q;
`else
   // Pass-through: fields are zero on the link whenever nothing is sent
   assign bus.link_valid = send;
   assign bus.link_data  = send ? bus.in_data : '0;
   assign bus.link_head  = send && bus.in_head;
   assign bus.link_tail  = send && bus.in_tail;
`endif

endmodule

// File: tb/tb_nw_credit_tx.sv
// Randomized and directed bench for nw_credit_tx with a scoreboard on the link side.
// Latency: expects link flits 0 cycles after pop, or 1 cycle with NW_CREDIT_TX_OUTREG_EN.
// Backpressure: upstream holds a flit until popped; downstream returns credits only for outstanding slots (except the overflow test).
module tb_nw_credit_tx;
   localparam int FLIT_W  = 64;
   localparam int CREDITS = 4;
   localparam int CNT_W   = $clog2(CREDITS + 1);
`ifdef NW_CREDIT_TX_OUTREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      logic [63:0] dat;
      logic        hd;
      logic        tl;
   } flit_t;

   typedef struct {
      logic [63:0] dat;
      logic        hd;
      logic        tl;
      int          cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [CNT_W-1:0] credits_avail;
   logic             idle;
   logic             err_credit;
   logic             err_frame;

   always #5 clk = ~clk;

   nw_credit_tx_if #(.FLIT_W(FLIT_W)) bus ();

   nw_credit_tx #(.FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .credits_avail(credits_avail),
      .idle         (idle),
      .err_credit   (err_credit),
      .err_frame    (err_frame)
   );

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   exp_t  sb[$];
   flit_t pend_q[$];

   // Reference state: free downstream slots, open-packet flag, sticky error expectations
   int    m_free;
   bit    m_pkt;
   bit    m_errc;
   bit    m_errf;
   int    pops;
   bit    up_vld;
   flit_t up;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive upstream/credit, predict, check at negedge, advance the model at posedge
   task automatic step(input bit cr, input bit feed);
      bit   exp_send;
      exp_t e;
      if (!up_vld && feed && pend_q.size() > 0) begin
         up     = pend_q.pop_front();
         up_vld = 1'b1;
      end
      bus.in_valid  = up_vld;
      bus.in_data   = up_vld ? up.dat : 64'h0;
      bus.in_head   = up_vld ? up.hd : 1'b0;
      bus.in_tail   = up_vld ? up.tl : 1'b0;
      bus.credit_in = cr;
      exp_send = up_vld && (m_free != 0);
      if (exp_send) begin
         e.dat = up.dat;
         e.hd  = up.hd;
         e.tl  = up.tl;
         e.cyc = cyc + LAT;
         sb.push_back(e);
      end
      @(negedge clk);
      chk("in_pop", 64'(bus.in_pop), 64'(exp_send));
      chk("credits_avail", 64'(credits_avail), 64'(m_free));
      chk("err_credit", 64'(err_credit), 64'(m_errc));
      chk("err_frame", 64'(err_frame), 64'(m_errf));
      chk("idle", 64'(idle), 64'(!m_pkt && m_free == CREDITS));
      @(posedge clk);
      if (exp_send) begin
         pops++;
         if ((!m_pkt && !up.hd) || (m_pkt && up.hd)) m_errf = 1'b1;
         m_pkt  = !up.tl;
         up_vld = 1'b0;
      end
      if (cr && !exp_send) begin
         if (m_free == CREDITS) m_errc = 1'b1;
         else m_free++;
      end else if (exp_send && !cr) begin
         m_free--;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.in_head   = 1'b1;
      bus.in_tail   = 1'b0;
      bus.credit_in = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_pop", 64'(bus.in_pop), 64'd0);
      chk("rst_link_valid", 64'(bus.link_valid), 64'd0);
      chk("rst_credits", 64'(credits_avail), 64'(CREDITS));
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_err_credit", 64'(err_credit), 64'd0);
      chk("rst_err_frame", 64'(err_frame), 64'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_free = CREDITS;
      m_pkt  = 1'b0;
      m_errc = 1'b0;
      m_errf = 1'b0;
      up_vld = 1'b0;
      pend_q.delete();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) step(m_free < CREDITS, 1'b1);
   endtask

   task automatic push_pkt(input int len, input logic [63:0] base);
      flit_t f;
      for (int i = 0; i < len; i++) begin
         f.dat = base + 64'(i);
         f.hd  = (i == 0);
         f.tl  = (i == len - 1);
         pend_q.push_back(f);
      end
   endtask

   // Link monitor: every valid link flit must match the oldest expectation, on its predicted cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.link_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL link_unexpected data=%0h at cycle %0d", bus.link_data, cyc);
            end else begin
               e = sb.pop_front();
               chk("link_data", bus.link_data, e.dat);
               chk("link_head", 64'(bus.link_head), 64'(e.hd));
               chk("link_tail", 64'(bus.link_tail), 64'(e.tl));
               chk("link_cycle", 64'(cyc), 64'(e.cyc));
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL link_missing expected=%0h at cycle %0d", sb[0].dat, cyc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      flit_t f;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_head   = 1'b0;
      bus.in_tail   = 1'b0;
      bus.credit_in = 1'b0;
      up_vld        = 1'b0;
      @(posedge clk);
      #1;

      // Credit exhaustion: 6-flit packet, no returns, then a single credit pulse
      do_reset();
      pops = 0;
      push_pkt(6, 64'h100);
      repeat (6) step(1'b0, 1'b1);
      chk("exh_pops", 64'(pops), 64'd4);
      chk("exh_credits", 64'(credits_avail), 64'd0);
      chk("exh_stall", 64'(bus.in_pop), 64'd0);
      step(1'b1, 1'b1);
      chk("exh_no_same_cycle", 64'(pops), 64'd4);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("exh_one_more", 64'(pops), 64'd5);
      drain();

      // Simultaneous send and credit return keeps the count at 2
      do_reset();
      push_pkt(14, 64'h200);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      pops = 0;
      repeat (10) step(1'b1, 1'b1);
      chk("simul_pops", 64'(pops), 64'd10);
      chk("simul_credits", 64'(credits_avail), 64'd2);
      drain();

      // Credit overflow while idle and full
      do_reset();
      step(1'b1, 1'b1);
      chk("ovf_err", 64'(err_credit), 64'd1);
      chk("ovf_credits", 64'(credits_avail), 64'(CREDITS));
      repeat (5) step(1'b0, 1'b1);
      chk("ovf_sticky", 64'(err_credit), 64'd1);

      // Framing: body flit from IDLE, then a head inside a packet
      do_reset();
      f.dat = 64'hA5; f.hd = 1'b0; f.tl = 1'b0; pend_q.push_back(f);
      f.dat = 64'hA6; f.hd = 1'b0; f.tl = 1'b1; pend_q.push_back(f);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("frame_err_body", 64'(err_frame), 64'd1);
      drain();
      do_reset();
      f.dat = 64'h1; f.hd = 1'b1; f.tl = 1'b0; pend_q.push_back(f);
      f.dat = 64'h2; f.hd = 1'b1; f.tl = 1'b0; pend_q.push_back(f);
      f.dat = 64'h3; f.hd = 1'b0; f.tl = 1'b1; pend_q.push_back(f);
      step(1'b0, 1'b1);
      chk("frame_ok_head", 64'(err_frame), 64'd0);
      step(1'b0, 1'b1);
      chk("frame_err_head", 64'(err_frame), 64'd1);
      drain();

      // Single-flit packet 0x11: monitor checks arrival cycle against the link latency
      do_reset();
      f.dat = 64'h11; f.hd = 1'b1; f.tl = 1'b1; pend_q.push_back(f);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("single_flit_sb", 64'(sb.size()), 64'd0);
      drain();

      // Random traffic: bursty upstream, random credit returns, occasional framing faults
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (pend_q.size() == 0) begin
            int len;
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
               f.dat = {$urandom, $urandom};
               f.hd  = (i == 0);
               f.tl  = (i == len - 1);
               if ($urandom % 20 == 0) f.hd = ~f.hd;
               pend_q.push_back(f);
            end
         end
         step((m_free < CREDITS) && ($urandom % 3 != 0), ($urandom % 10) < 7);
      end
      drain();
      repeat (2) step(1'b0, 1'b0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
